// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF neuron array: FSM states, default
// sizing and the saturating add used for membrane integration.
package lif_pkg;

  typedef enum logic [1:0] {
    LIF_IDLE = 2'd0,
    LIF_SCAN = 2'd1,
    LIF_DONE = 2'd2
  } lif_state_e;

  localparam int                 DEF_N_NEURONS  = 8;
  localparam int                 DEF_W_POT      = 16;
  localparam logic signed [15:0] DEF_THRESHOLD  = 16'sh2710;
  localparam int                 DEF_REFRACT    = 4;
  localparam int                 DEF_LEAK_SHIFT = 4;

  // Sum carried one bit wider than any supported potential (up to 32 bits),
  // then clamped to the signed range of a w-bit value.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi)      return hi[31:0];
    else if (s < lo) return lo[31:0];
    else             return s[31:0];
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational next-state for one neuron, shared across the array.
// Leak during the scan is enabled by defining LIF_LEAK_EN.
module lif_update
  import lif_pkg::*;
#(
  parameter int                        W_POT      = DEF_W_POT,
  parameter int                        RW         = 3,
  parameter logic signed [W_POT-1:0]   THRESHOLD  = DEF_THRESHOLD,
  parameter int                        REFRACT    = DEF_REFRACT,
  parameter int                        LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic                    scan,
  input  logic signed [W_POT-1:0] pot,
  input  logic        [RW-1:0]    refr,
  input  logic signed [W_POT-1:0] weight,
  output logic signed [W_POT-1:0] pot_nxt,
  output logic        [RW-1:0]    refr_nxt,
  output logic                    fire
);

`ifdef LIF_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  // Arithmetic shift rounds toward -inf, so the subtraction never crosses zero.
  function automatic logic signed [W_POT-1:0] leak(input logic signed [W_POT-1:0] p);
    return p - (p >>> LEAK_SHIFT);
  endfunction

  logic signed [31:0] sum_w;

  assign sum_w = sat_add(32'(pot), 32'(weight), W_POT);

  always_comb begin
    pot_nxt  = pot;
    refr_nxt = refr;
    fire     = 1'b0;
    if (scan) begin
      if (refr != '0) begin
        refr_nxt = refr - RW'(1);
        pot_nxt  = '0;
      end else if (pot >= THRESHOLD) begin
        pot_nxt  = '0;
        refr_nxt = RW'(REFRACT);
        fire     = 1'b1;
      end else if (LEAK_ON) begin
        pot_nxt  = leak(pot);
      end
    end else if (refr == '0) begin
      pot_nxt = sum_w[W_POT-1:0];
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of LIF neurons: integrates weighted events while idle
// and scans every neuron once per tick. Optional leak via LIF_LEAK_EN.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int                      N_NEURONS  = DEF_N_NEURONS,
  parameter int                      W_POT      = DEF_W_POT,
  parameter logic signed [W_POT-1:0] THRESHOLD  = DEF_THRESHOLD,
  parameter int                      REFRACT    = DEF_REFRACT,
  parameter int                      LEAK_SHIFT = DEF_LEAK_SHIFT,
  localparam int                     IW         = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [IW-1:0]    in_idx,
  input  logic signed [W_POT-1:0] in_weight,
  input  logic                    tick,
  output logic                    spike_valid,
  output logic        [IW-1:0]    spike_idx,
  output logic                    scan_done,
  output logic                    tick_overrun
);

  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  lif_state_e state, state_nxt;

  logic        [IW-1:0]    scan_idx;
  logic signed [W_POT-1:0] pot  [N_NEURONS];
  logic        [RW-1:0]    refr [N_NEURONS];

  logic                    scan_act;
  logic                    scan_last;
  logic                    accept;
  logic        [IW-1:0]    sel_idx;
  logic                    sel_ok;
  logic signed [W_POT-1:0] sel_pot;
  logic        [RW-1:0]    sel_refr;
  logic signed [W_POT-1:0] pot_nxt;
  logic        [RW-1:0]    refr_nxt;
  logic                    fire;
  logic                    wr_en;
  logic                    spike_vld_p1;
  logic        [IW-1:0]    spike_idx_p1;
  logic                    overrun;

  assign in_ready  = en & ~rst & (state == LIF_IDLE);
  assign accept    = in_valid & in_ready;
  assign scan_act  = (state == LIF_SCAN);
  assign scan_last = (scan_idx == IW'(N_NEURONS - 1));

  // One update slice serves the accumulate port in IDLE and the scan in SCAN.
  assign sel_idx  = scan_act ? scan_idx : in_idx;
  assign sel_ok   = (int'(sel_idx) < N_NEURONS);
  assign sel_pot  = sel_ok ? pot[sel_idx]  : '0;
  assign sel_refr = sel_ok ? refr[sel_idx] : '0;
  assign wr_en    = sel_ok & (scan_act ? en : accept);

  lif_update #(
    .W_POT      (W_POT),
    .RW         (RW),
    .THRESHOLD  (THRESHOLD),
    .REFRACT    (REFRACT),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_update (
    .scan     (scan_act),
    .pot      (sel_pot),
    .refr     (sel_refr),
    .weight   (in_weight),
    .pot_nxt  (pot_nxt),
    .refr_nxt (refr_nxt),
    .fire     (fire)
  );

  always_comb begin
    state_nxt = state;
    if (en) begin
      unique case (state)
        LIF_IDLE: if (tick)      state_nxt = LIF_SCAN;
        LIF_SCAN: if (scan_last) state_nxt = LIF_DONE;
        LIF_DONE:                state_nxt = LIF_IDLE;
        default:                 state_nxt = LIF_IDLE;
      endcase
    end
  end

  // p1: neuron evaluation registered into the arrays and the spike output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LIF_IDLE;
      scan_idx     <= '0;
      spike_vld_p1 <= 1'b0;
      spike_idx_p1 <= '0;
      overrun      <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        pot[i]  <= '0;
        refr[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (wr_en) begin
        pot[sel_idx]  <= pot_nxt;
        refr[sel_idx] <= refr_nxt;
      end
      if (en) begin
        spike_vld_p1 <= scan_act & fire;
        if (scan_act & fire) spike_idx_p1 <= scan_idx;
        if (scan_act)        scan_idx     <= scan_last ? '0 : scan_idx + IW'(1);
        if (tick && state != LIF_IDLE) overrun <= 1'b1;
      end
    end
  end

  // A held spike reappears when en returns, so a stall delays it rather than dropping it.
  assign spike_valid  = spike_vld_p1 & en;
  assign spike_idx    = spike_idx_p1;
  assign scan_done    = en & (state == LIF_DONE);
  assign tick_overrun = overrun;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array (N=8, W_POT=16, REFRACT=4).
module tb_lif_neuron_array;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int NC = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [IW-1:0]      in_idx = '0;
  logic signed [15:0] in_weight = '0;
  logic               tick = 1'b0;
  logic               spike_valid;
  logic [IW-1:0]      spike_idx;
  logic               scan_done;
  logic               tick_overrun;

  int n_cmp = 0;
  int n_err = 0;
  int nspk;
  int ndone;
  logic sv [0:NC];
  int   si [0:NC];
  logic sd [0:NC];

  lif_neuron_array dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_idx       (in_idx),
    .in_weight    (in_weight),
    .tick         (tick),
    .spike_valid  (spike_valid),
    .spike_idx    (spike_idx),
    .scan_done    (scan_done),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input int idx, input int w);
    in_valid  = 1'b1;
    in_idx    = IW'(idx);
    in_weight = 16'(w);
    step();
    in_valid  = 1'b0;
  endtask

  task automatic start_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Records outputs for cycles k+1..k+NC after the tick edge k.
  task automatic capture(input int tick_c, input int en_from, input int en_len, input int rst_c);
    nspk  = 0;
    ndone = 0;
    for (int c = 1; c <= NC; c++) begin
      tick = (c == tick_c);
      en   = !(c >= en_from && c < en_from + en_len);
      rst  = (c == rst_c);
      #1;
      sv[c] = spike_valid;
      si[c] = int'(spike_idx);
      sd[c] = scan_done;
      if (spike_valid) nspk++;
      if (scan_done)   ndone++;
      @(posedge clk);
      #1;
    end
    tick = 1'b0;
    en   = 1'b1;
    rst  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    step();
    step();
    check_eq("rst_spike_valid", 32'(spike_valid), 0);
    check_eq("rst_spike_idx", 32'(spike_idx), 0);
    check_eq("rst_scan_done", 32'(scan_done), 0);
    check_eq("rst_overrun", 32'(tick_overrun), 0);
    check_eq("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    check_eq("in_ready_en1", 32'(in_ready), 1);
    en = 1'b0;
    #1;
    check_eq("in_ready_en0", 32'(in_ready), 0);
    en = 1'b1;
    #1;

    // Accumulate and fire
    reset_dut();
    send(3, 6000);
    send(3, 4000);
    check_eq("acc_pot3", 32'(dut.pot[3]), 10000);
    start_tick();
    capture(0, 0, 0, 0);
    check_eq("fire_sv_k5", 32'(sv[5]), 1);
    check_eq("fire_idx_k5", 32'(si[5]), 3);
    check_eq("fire_nspk", 32'(nspk), 1);
    check_eq("fire_done_k8", 32'(sd[8]), 0);
    check_eq("fire_done_k9", 32'(sd[9]), 1);
    check_eq("fire_ndone", 32'(ndone), 1);
    check_eq("fire_pot3", 32'(dut.pot[3]), 0);
    check_eq("fire_no_overrun", 32'(tick_overrun), 0);

    // Saturation and refractory
    reset_dut();
    send(0, 30000);
    send(0, 30000);
    check_eq("sat_pot0", 32'(dut.pot[0]), 32767);
    send(0, -30000);
    send(0, -30000);
    send(0, -30000);
    check_eq("sat_neg_pot0", 32'(dut.pot[0]), 32'(-32768));
    send(0, 32767);
    send(0, 32767);
    check_eq("sat_back_pot0", 32'(dut.pot[0]), 32766);
    send(0, 1);
    for (int t = 1; t <= 6; t++) begin
      send(0, 20000);
      if (t == 2) check_eq("refr_discard_pot0", 32'(dut.pot[0]), 0);
      start_tick();
      capture(0, 0, 0, 0);
      check_eq($sformatf("refr_tick%0d_spike", t),
               32'(nspk == 1 && sv[2] && si[2] == 0), 32'(t == 1 || t == 6));
    end

    // Leak
    reset_dut();
    send(5, 1600);
    start_tick();
    capture(0, 0, 0, 0);
`ifdef LIF_LEAK_EN
    check_eq("leak_pos", 32'(dut.pot[5]), 1500);
`else
    check_eq("leak_pos", 32'(dut.pot[5]), 1600);
`endif
    reset_dut();
    send(5, -1);
    start_tick();
    capture(0, 0, 0, 0);
`ifdef LIF_LEAK_EN
    check_eq("leak_neg1", 32'(dut.pot[5]), 0);
`else
    check_eq("leak_neg1", 32'(dut.pot[5]), 32'(-1));
`endif

    // Simultaneous input with tick, then overrun
    reset_dut();
    in_valid  = 1'b1;
    in_idx    = '0;
    in_weight = 16'sd10000;
    tick      = 1'b1;
    step();
    in_valid  = 1'b0;
    tick      = 1'b0;
    capture(3, 0, 0, 0);
    check_eq("sim_sv_k2", 32'(sv[2]), 1);
    check_eq("sim_idx_k2", 32'(si[2]), 0);
    check_eq("sim_nspk", 32'(nspk), 1);
    check_eq("ovr_flag", 32'(tick_overrun), 1);
    check_eq("ovr_done_k9", 32'(sd[9]), 1);
    check_eq("ovr_ndone", 32'(ndone), 1);
    check_eq("ovr_in_ready", 32'(in_ready), 1);

    // en stall mid-scan delays every spike by the stall length
    reset_dut();
    send(2, 10000);
    send(6, 10000);
    start_tick();
    capture(0, 2, 3, 0);
    check_eq("stall_sv_k4", 32'(sv[4]), 0);
    check_eq("stall_sv_k7", 32'(sv[7]), 1);
    check_eq("stall_idx_k7", 32'(si[7]), 2);
    check_eq("stall_sv_k11", 32'(sv[11]), 1);
    check_eq("stall_idx_k11", 32'(si[11]), 6);
    check_eq("stall_nspk", 32'(nspk), 2);
    check_eq("stall_done_k9", 32'(sd[9]), 0);
    check_eq("stall_done_k12", 32'(sd[12]), 1);

    // Reset mid-scan
    reset_dut();
    send(1, 10000);
    send(7, 10000);
    start_tick();
    capture(0, 0, 0, 2);
    check_eq("rstmid_nspk", 32'(nspk), 0);
    check_eq("rstmid_ndone", 32'(ndone), 0);
    check_eq("rstmid_pot1", 32'(dut.pot[1]), 0);
    check_eq("rstmid_pot7", 32'(dut.pot[7]), 0);
    check_eq("rstmid_in_ready", 32'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
